// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding, NOP word,
// PC increment and the instruction-memory address check helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  // True when addr is misaligned or beyond the last full word of a mem_bytes memory.
  function automatic logic imem_addr_bad(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 32'd4));
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: clear wins over hold; when neither is set the
// fetched PC, PC+4 and instruction word are captured and marked valid.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        clear,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc_plus4,
  input  logic [31:0] fetch_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr
);

  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4_reg;
  logic [31:0] instr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      pc_reg       <= 32'd0;
      pc_plus4_reg <= 32'd0;
      instr_reg    <= NOP_WORD;
    end else if (clear) begin
      valid_reg    <= 1'b0;
      pc_reg       <= 32'd0;
      pc_plus4_reg <= 32'd0;
      instr_reg    <= NOP_WORD;
    end else if (!hold) begin
      valid_reg    <= 1'b1;
      pc_reg       <= fetch_pc;
      pc_plus4_reg <= fetch_pc_plus4;
      instr_reg    <= fetch_instr;
    end
  end

  assign ifid_valid    = valid_reg;
  assign ifid_pc       = pc_reg;
  assign ifid_pc_plus4 = pc_plus4_reg;
  assign ifid_instr    = instr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/FETCH/FAULT control and IF/ID register.
// Define IMEM_BOUNDS_CHECK_EN to trap misaligned or out-of-range next-PC values.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        fetch_fault
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  seq_pc;
  logic [31:0]  cand_pc;
  logic         pc_load;
  logic         ifid_hold;
  logic         ifid_clear;

  assign seq_pc = pc_reg + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_pc    = seq_pc;
    pc_load    = 1'b0;
    ifid_hold  = 1'b1;
    ifid_clear = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        ifid_clear = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          cand_pc    = redirect_target;
          pc_load    = 1'b1;
          ifid_clear = 1'b1;
        end else if (flush) begin
          pc_load    = !stall;
          ifid_clear = 1'b1;
        end else if (!stall) begin
          pc_load    = 1'b1;
          ifid_hold  = 1'b0;
        end
`ifdef IMEM_BOUNDS_CHECK_EN
        // A bad next-PC is never loaded; the stage parks in FAULT with IF/ID invalid.
        if (pc_load && imem_addr_bad(cand_pc, 32'(IMEM_BYTES))) begin
          pc_load    = 1'b0;
          ifid_hold  = 1'b1;
          ifid_clear = 1'b1;
          state_next = ST_FAULT;
        end
`endif
      end
      ST_FAULT: begin
        ifid_hold = 1'b1;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
    pc_next = pc_load ? cand_pc : pc_reg;
  end

  ifid_reg u_ifid_reg (
    .clk            (clk),
    .rst            (rst),
    .hold           (ifid_hold),
    .clear          (ifid_clear),
    .fetch_pc       (pc_reg),
    .fetch_pc_plus4 (seq_pc),
    .fetch_instr    (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr)
  );

  assign imem_pc = pc_reg;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fetch_fault = (state_reg == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 512, byte size of the instruction memory fed by imem_pc.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 stall  input  1  hold PC and IF/ID register contents.
REQ-006 flush  input  1  invalidate IF/ID contents at next edge.
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_target  input  32  byte address of next fetch when redirect_valid=1.
REQ-009 imem_instr  input  32  big-endian word returned combinationally by instruction memory for imem_pc.
REQ-010 imem_pc  output  32  current PC, driven to instruction memory address.
REQ-011 ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-012 ifid_pc  output  32  PC of the instruction in IF/ID.
REQ-013 ifid_pc_plus4  output  32  ifid_pc + 4.
REQ-014 ifid_instr  output  32  instruction word in IF/ID; 32'h0000_0000 (NOP) when ifid_valid=0.
REQ-015 fetch_fault  output  1  sticky fetch-address fault flag.

Function
REQ-016 The FSM SHALL have states BOOT, FETCH, FAULT; reset enters BOOT.
REQ-017 BOOT SHALL last exactly one cycle after rst deasserts, drive imem_pc=RESET_PC, keep ifid_valid=0, then go to FETCH.
REQ-018 In FETCH, with no stall/flush/redirect, each edge SHALL capture {imem_pc, imem_instr} into IF/ID, set ifid_valid=1, and advance PC by 4 (fetch latency one cycle).
REQ-019 Priority SHALL be redirect_valid > flush > stall > sequential advance.
REQ-020 redirect_valid=1 SHALL load PC=redirect_target and clear IF/ID (ifid_valid=0, ifid_instr=NOP) at the same edge, regardless of stall.
REQ-021 flush=1 without redirect SHALL clear IF/ID and advance PC by 4 unless stall=1, in which case PC holds.
REQ-022 stall=1 alone SHALL hold PC and all IF/ID outputs unchanged.
REQ-023 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-024 ifid_pc_plus4 SHALL be registered together with ifid_pc, never recomputed from imem_pc.
REQ-025 In FAULT, PC and IF/ID SHALL freeze with ifid_valid=0; only rst exits FAULT.

Reset
REQ-026 Asserting rst at any time, including mid-stall or mid-redirect, SHALL immediately force: PC=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP, fetch_fault=0, state=BOOT.
REQ-027 Inputs SHALL be ignored while rst=1.

Configuration
REQ-028 Macro IMEM_BOUNDS_CHECK_EN SHALL enable address checking: a next-PC with bits[1:0]!=0 or > IMEM_BYTES-4 SHALL not be loaded; instead state goes to FAULT and fetch_fault=1 at that edge.
REQ-029 Without IMEM_BOUNDS_CHECK_EN, no check is made, FAULT is unreachable, and fetch_fault SHALL be constant 0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the NOP word constant, and the PC increment constant (4).
REQ-031 One sub-module, ifid_reg, SHALL implement the IF/ID pipeline register with hold/clear controls; PC register and FSM stay in fetch_stage.

Verification
REQ-032 Reset release, imem_instr=32'h2402_0006 at PC 0 -> BOOT cycle with imem_pc=0, ifid_valid=0; next edge ifid_pc=0, ifid_pc_plus4=4, ifid_instr=32'h2402_0006, imem_pc=4.
REQ-033 Five free-running cycles from PC 0 -> ifid_pc sequence 0,4,8,12,16 with ifid_valid=1 throughout.
REQ-034 stall=1 for 3 cycles at imem_pc=8 -> imem_pc stays 8, IF/ID holds PC 4 contents; release -> ifid_pc=8 next edge.
REQ-035 redirect_valid=1, redirect_target=32'h0000_0040 together with stall=1 -> imem_pc=0x40, ifid_valid=0 next edge; following edge ifid_pc=0x40.
REQ-036 With IMEM_BOUNDS_CHECK_EN, redirect_target=32'h0000_0202 -> fetch_fault=1, ifid_valid=0, imem_pc frozen; rst -> fetch_fault=0, imem_pc=0.
REQ-037 rst asserted asynchronously mid-cycle during flush -> all outputs take reset values before next clk edge.
